// File: rtl/led_pkg.sv
// Shared definitions for the LED fader: per-channel fade states and default resolution.
package led_pkg;

  localparam int PWM_BITS_DEF = 8;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_RISING  = 2'd1,
    ST_ON      = 2'd2,
    ST_FALLING = 2'd3
  } fade_state_e;

endpackage

// File: rtl/led_fader_if.sv
// Request/drive bundle between the LED fader and its user: on/off requests in, PWM pins and busy out.
interface led_fader_if #(
  parameter int NUM_LEDS = 4
);

  logic [NUM_LEDS-1:0] REQ;
  logic [NUM_LEDS-1:0] LED;
  logic                BUSY;

  modport master (output REQ, input LED, input BUSY);
  modport slave  (input REQ, output LED, output BUSY);

endinterface

// File: rtl/led_fader_tick_divider.sv
// Free-running divider: tick_o is high for one cycle out of every DIV, first time DIV cycles after reset.
module tick_divider #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // wrap at DIV-1
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q == LAST) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/led_fader.sv
// Multi-channel LED fader: each channel ramps its PWM brightness up/down following its request.
// Define LED_FADER_GAMMA_EN for a squared (perceptual) brightness curve; default is linear.
module led_fader
  import led_pkg::*;
#(
  parameter int FREQ     = 12000000,
  parameter int NUM_LEDS = 4,
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int PWM_DIV  = (FREQ + 128000) / 256000,
  parameter int STEP_DIV = FREQ / 512
) (
  input  logic        CLK,
  input  logic        RST_N,
  led_fader_if.slave  bus
);

  localparam logic [PWM_BITS-1:0] MAX  = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] ZERO = {PWM_BITS{1'b0}};
  localparam logic [PWM_BITS-1:0] ONE  = {{(PWM_BITS-1){1'b0}}, 1'b1};

  logic                pwm_tick_s;
  logic                step_tick_s;
  logic [NUM_LEDS-1:0] req_q;
  logic [NUM_LEDS-1:0] led_q;
  logic [NUM_LEDS-1:0] led_d;
  logic [NUM_LEDS-1:0] active_s;
  logic                busy_q;
  logic                busy_d;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [PWM_BITS-1:0] pwm_cnt_d;

  tick_divider #(.DIV(PWM_DIV)) u_pwm_div (
    .clk    (CLK),
    .rst_n  (RST_N),
    .tick_o (pwm_tick_s)
  );

  tick_divider #(.DIV(STEP_DIV)) u_step_div (
    .clk    (CLK),
    .rst_n  (RST_N),
    .tick_o (step_tick_s)
  );

  // request capture, PWM counter and output pins
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      req_q     <= {NUM_LEDS{1'b0}};
      pwm_cnt_q <= ZERO;
      led_q     <= {NUM_LEDS{1'b0}};
      busy_q    <= 1'b0;
    end else begin
      req_q     <= bus.REQ;
      pwm_cnt_q <= pwm_cnt_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
    end
  end

  // PWM counter advances on pwm_tick and wraps naturally at MAX
  always_comb begin
    pwm_cnt_d = pwm_cnt_q;
    if (pwm_tick_s) begin
      pwm_cnt_d = pwm_cnt_q + ONE;
    end else begin
      pwm_cnt_d = pwm_cnt_q;
    end
  end

  assign busy_d   = |active_s;
  assign bus.LED  = led_q;
  assign bus.BUSY = busy_q;

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    fade_state_e         state_q;
    fade_state_e         state_d;
    logic [PWM_BITS-1:0] level_q;
    logic [PWM_BITS-1:0] level_d;
    logic [PWM_BITS-1:0] duty_s;
    logic                active_ch_s;
    logic                led_ch_s;

    // channel state and brightness
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        state_q <= ST_OFF;
        level_q <= ZERO;
      end else begin
        state_q <= state_d;
        level_q <= level_d;
      end
    end

    // direction reverses immediately on a request change
    always_comb begin
      state_d = state_q;
      case (state_q)
        ST_OFF: begin
          if (req_q[i]) state_d = ST_RISING;
          else          state_d = ST_OFF;
        end
        ST_RISING: begin
          if (!req_q[i])           state_d = ST_FALLING;
          else if (level_q == MAX) state_d = ST_ON;
          else                     state_d = ST_RISING;
        end
        ST_ON: begin
          if (!req_q[i]) state_d = ST_FALLING;
          else           state_d = ST_ON;
        end
        ST_FALLING: begin
          if (req_q[i])             state_d = ST_RISING;
          else if (level_q == ZERO) state_d = ST_OFF;
          else                      state_d = ST_FALLING;
        end
        default: state_d = ST_OFF;
      endcase
    end

    // the step follows the post-change direction, saturating at both ends
    always_comb begin
      level_d = level_q;
      if (step_tick_s && (state_d == ST_RISING) && (level_q != MAX)) begin
        level_d = level_q + ONE;
      end else if (step_tick_s && (state_d == ST_FALLING) && (level_q != ZERO)) begin
        level_d = level_q - ONE;
      end else begin
        level_d = level_q;
      end
      active_ch_s = (state_q == ST_RISING) || (state_q == ST_FALLING);
    end

`ifdef LED_FADER_GAMMA_EN
    logic [2*PWM_BITS-1:0] sq_s;
    assign sq_s = {{PWM_BITS{1'b0}}, level_q} * {{PWM_BITS{1'b0}}, level_q};

    // squared curve, full scale pinned to MAX
    always_comb begin
      duty_s = ZERO;
      if (level_q == MAX) begin
        duty_s = MAX;
      end else begin
        duty_s = sq_s[2*PWM_BITS-1:PWM_BITS];
      end
    end
`else
    assign duty_s = level_q;
`endif

    assign led_ch_s    = (duty_s == MAX) || (pwm_cnt_q < duty_s);
    assign led_d[i]    = led_ch_s;
    assign active_s[i] = active_ch_s;
  end

endmodule

// File: doc/led_fader.md
LED_FADER -- requirements
Module: led_fader

Interface
REQ-001 Parameter FREQ, default 12000000, input clock frequency in Hz (informational; used only for default derivation).
REQ-002 Parameter NUM_LEDS, default 4, number of independent LED channels.
REQ-003 Parameter PWM_BITS, default 8, brightness/PWM resolution; MAX = 2^PWM_BITS-1.
REQ-004 Parameter PWM_DIV, default 47, clock cycles per PWM counter increment (12 MHz / 47 / 256 = about 1 kHz PWM).
REQ-005 Parameter STEP_DIV, default 23437, clock cycles per fade step (full fade 0->255 in about 0.5 s).
REQ-006 CLK  input  1  single clock; all state on rising edge.
REQ-007 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-008 REQ  input  NUM_LEDS  per-channel on/off request, synchronous to CLK (e.g. second_counter outputs).
REQ-009 LED  output  NUM_LEDS  per-channel PWM drive to the LED pin, registered.
REQ-010 BUSY  output  1  high while any channel is in RISING or FALLING.

Function
REQ-011 REQ shall be registered once; all decisions use the registered copy (1-cycle input latency).
REQ-012 pwm_tick shall pulse for one cycle every PWM_DIV cycles; step_tick shall pulse for one cycle every STEP_DIV cycles; both free-running from reset.
REQ-013 A PWM_BITS-wide pwm_cnt shall increment on pwm_tick and wrap from MAX to 0.
REQ-014 Each channel shall hold level[i] in 0..MAX and a state: OFF, RISING, ON, FALLING.
REQ-015 Transitions: OFF->RISING when req=1; RISING->ON when level reaches MAX; ON->FALLING when req=0; FALLING->OFF when level reaches 0.
REQ-016 RISING with req=0 shall go to FALLING, and FALLING with req=1 shall go to RISING, immediately, from the current level with no jump.
REQ-017 On step_tick, RISING shall add 1 to level and FALLING shall subtract 1; level shall saturate and never wrap.
REQ-018 If step_tick and a req change occur in the same cycle, the direction after the change applies to that step.
REQ-019 LED[i] shall be registered as 1 when duty[i]==MAX or pwm_cnt < duty[i], and 0 otherwise; duty 0 gives constant 0 and duty MAX gives constant 1.
REQ-020 BUSY shall be the registered OR of (state==RISING or state==FALLING) over all channels.

Reset
REQ-021 With RST_N low, LED=0, BUSY=0, every level=0, every state=OFF, pwm_cnt=0, both dividers=0, and the registered REQ=0, taking effect asynchronously.
REQ-022 Reset deassertion mid-fade shall restart every channel from OFF/level 0; the first pwm_tick shall occur PWM_DIV cycles after release.

Configuration
REQ-023 Macro LED_FADER_GAMMA_EN defined: duty[i] = (level[i]*level[i]) >> PWM_BITS, with duty forced to MAX when level==MAX (perceptual fade).
REQ-024 Macro LED_FADER_GAMMA_EN undefined: duty[i] = level[i] (linear); no multiplier shall be synthesized.

Structure
REQ-025 The shared package or header led_pkg shall hold the state encodings (OFF=0, RISING=1, ON=2, FALLING=3) and the default PWM_BITS.
REQ-026 One sub-module, tick_divider (parameter DIV, outputs a 1-cycle pulse), shall be instantiated twice, once for pwm_tick and once for step_tick.
REQ-027 Channels shall be built with a generate loop over NUM_LEDS.

Verification (PWM_BITS=4, PWM_DIV=1, STEP_DIV=4, NUM_LEDS=4)
REQ-028 Reset, then REQ=0 for 200 cycles -> LED=0000, BUSY=0 throughout.
REQ-029 REQ[0] rises -> level[0] reaches 15 after 60 cycles (±4), state ON, LED[0] constant 1, BUSY falls; LED[3:1]=0.
REQ-030 From ON, REQ[0] low at level 15 and high again at level 9 -> level climbs from 9 back to 15 with no discontinuity; never wraps below 0 or above 15.
REQ-031 Level held at 8, linear build -> LED[0] high for exactly 8 of every 16 cycles; with LED_FADER_GAMMA_EN -> duty 4, high for 4 of every 16 cycles.
REQ-032 RST_N pulsed low for 1 cycle mid-fade on all channels -> LED=0000 asynchronously; after release all channels OFF and level=0.
REQ-033 REQ toggled in the same cycle as step_tick -> level moves in the new direction on that step.
